// File: rtl/tile_mem_arb_pkg.sv
// rtl/tile_mem_arb_pkg.sv - shared encodings and helpers for the tile memory arbiter
package tile_mem_arb_pkg;

    typedef enum logic {
        M_XRD = 1'b0,
        M_XWR = 1'b1
    } mem_fcn_e;

    typedef enum logic [2:0] {
        MT_X  = 3'd0,
        MT_B  = 3'd1,
        MT_H  = 3'd2,
        MT_W  = 3'd3,
        MT_BU = 3'd5,
        MT_HU = 3'd6
    } mem_typ_e;

    localparam int MAX_PORTS = 16;

    function automatic int id_width_f(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    function automatic logic [MAX_PORTS-1:0] onehot_f(input logic [3:0] id);
        return MAX_PORTS'(1) << id;
    endfunction

endpackage

// File: rtl/tile_arb_id_fifo.sv
// rtl/tile_arb_id_fifo.sv - requester-ID FIFO tracking in-flight memory requests in issue order
module tile_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/tile_mem_arbiter.sv
// rtl/tile_mem_arbiter.sv - round-robin N-to-1 tile memory arbiter with in-order response routing
// Define TILE_MEM_ARB_PERF_EN to add per-port grant counters and a stall counter.
module tile_mem_arbiter
    import tile_mem_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    input  logic [NUM_PORTS-1:0]        req_fcn,
    input  logic [NUM_PORTS*3-1:0]      req_typ,
    output logic [NUM_PORTS-1:0]        resp_valid,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic [DATA_W-1:0]           mem_req_wdata,
    output logic                        mem_req_fcn,
    output logic [2:0]                  mem_req_typ,
    input  logic                        mem_resp_valid,
    input  logic [DATA_W-1:0]           mem_resp_rdata
`ifdef TILE_MEM_ARB_PERF_EN
    ,
    output logic [NUM_PORTS*32-1:0]     grant_cnt,
    output logic [31:0]                 stall_cnt
`endif
);

    localparam int ID_W  = id_width_f(NUM_PORTS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  idx;
    logic [ID_W-1:0]  head_id;
    logic             any_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fire;
    logic             pop;
    logic [CNT_W-1:0] unused_fifo_count;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        winner    = '0;
        idx       = '0;
        any_valid = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_PORTS);
            if (req_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    assign mem_req_addr  = req_addr[int'(winner)*ADDR_W +: ADDR_W];
    assign mem_req_wdata = req_wdata[int'(winner)*DATA_W +: DATA_W];
    assign mem_req_fcn   = req_fcn[winner];
    assign mem_req_typ   = req_typ[int'(winner)*3 +: 3];

    // rst gating keeps the combinational handshake outputs at zero during reset.
    assign mem_req_valid = !rst && any_valid && !fifo_full;
    assign fire          = mem_req_valid && mem_req_ready;
    assign req_ready     = fire ? NUM_PORTS'(onehot_f(4'(winner))) : '0;
    assign pop           = mem_resp_valid && !fifo_empty;

    tile_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fire),
        .push_data (winner),
        .pop       (pop),
        .head      (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (unused_fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (fire) begin
            rr_ptr <= (int'(winner) == NUM_PORTS - 1) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= '0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= '0;
            if (pop) begin
                resp_valid <= NUM_PORTS'(onehot_f(4'(head_id)));
                resp_rdata <= mem_resp_rdata;
            end
        end
    end

`ifdef TILE_MEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fire) begin
                grant_cnt[int'(winner)*32 +: 32] <= grant_cnt[int'(winner)*32 +: 32] + 32'd1;
            end
            if (any_valid && !fire) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tile_mem_arbiter.sv
// tb/tb_tile_mem_arbiter.sv - self-checking bench for tile_mem_arbiter (vectors, corner sequences, random vs queue model)
module tb_tile_mem_arbiter;
    import tile_mem_arb_pkg::*;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]    req_valid, req_ready, req_fcn, resp_valid;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [NP*3-1:0]  req_typ;
    logic [DW-1:0]    resp_rdata;
    logic             mem_req_valid, mem_req_ready, mem_req_fcn, mem_resp_valid;
    logic [AW-1:0]    mem_req_addr;
    logic [DW-1:0]    mem_req_wdata, mem_resp_rdata;
    logic [2:0]       mem_req_typ;
`ifdef TILE_MEM_ARB_PERF_EN
    logic [NP*32-1:0] grant_cnt;
    logic [31:0]      stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    tile_mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_fcn(req_fcn), .req_typ(req_typ),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_fcn(mem_req_fcn), .mem_req_typ(mem_req_typ),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
`ifdef TILE_MEM_ARB_PERF_EN
        , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] d,
                            input logic f, input logic [2:0] t);
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = d;
        req_fcn[p]            = f;
        req_typ[p*3 +: 3]     = t;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '1; mem_req_ready = 1'b1;
        req_addr = '0; req_wdata = '0; req_fcn = '0; req_typ = '0;
        mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        @(negedge clk); #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
        @(negedge clk);
        req_valid = '0; mem_req_ready = 1'b0;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NP-1:0] valid;
        logic          ready;
        logic [NP-1:0] exp_ready;
        logic          exp_mval;
        int            exp_port;
    } vec_t;
    vec_t vecs[7];

    // random-phase reference model state
    logic        pend[NP];
    logic [31:0] p_addr[NP], p_wdata[NP];
    logic        p_fcn[NP];
    logic [2:0]  p_typ[NP];
    int          idq[$];
    logic [31:0] memq[$];
    int          rr_m, w, fires;
    logic        exp_mv, fire_m;
    logic [NP-1:0] exp_rv;
    logic [DW-1:0] exp_rd;
    logic [31:0] ord_data[3];
    logic [NP-1:0] ord_hot[3];

    initial begin
        vecs[0] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};
        vecs[1] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 0};
        vecs[2] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 1};
        vecs[3] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 3};
        vecs[4] = '{4'b1100, 1'b0, 4'b0000, 1'b1, 2};
        vecs[5] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
        vecs[6] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1};

        // Combinational arbitration from rr_ptr=0; valid drops before each edge so nothing fires.
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, 32'h1000 + 32'(p*16), 32'hD0 + 32'(p), p[0], 3'(p));
        for (int i = 0; i < 7; i++) begin
            req_valid = vecs[i].valid; mem_req_ready = vecs[i].ready;
            #1;
            chk("vec_req_ready", 64'(req_ready), 64'(vecs[i].exp_ready));
            chk("vec_mem_req_valid", 64'(mem_req_valid), 64'(vecs[i].exp_mval));
            if (vecs[i].exp_mval) begin
                chk("vec_addr", 64'(mem_req_addr), 64'(32'h1000 + 32'(vecs[i].exp_port*16)));
                chk("vec_wdata", 64'(mem_req_wdata), 64'(32'hD0 + 32'(vecs[i].exp_port)));
                chk("vec_typ", 64'(mem_req_typ), 64'(vecs[i].exp_port));
            end
            #1 req_valid = '0;
            @(negedge clk);
        end

        // Single port read, memory latency 3
        do_reset();
        set_port(2, 32'h100, 32'h0, M_XRD, MT_W);
        req_valid = 4'b0100; mem_req_ready = 1'b1;
        #1;
        chk("sp_mem_req_valid", 64'(mem_req_valid), 64'(1));
        chk("sp_mem_req_addr", 64'(mem_req_addr), 64'(32'h100));
        chk("sp_mem_req_fcn", 64'(mem_req_fcn), 64'(0));
        chk("sp_mem_req_typ", 64'(mem_req_typ), 64'(MT_W));
        chk("sp_req_ready", 64'(req_ready), 64'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEADBEEF;
        #1 chk("sp_resp_early", 64'(resp_valid), 64'(0));
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("sp_resp_valid", 64'(resp_valid), 64'(4'b0100));
        chk("sp_resp_rdata", 64'(resp_rdata), 64'(32'hDEADBEEF));
        @(negedge clk); #1;
        chk("sp_resp_clear", 64'(resp_valid), 64'(0));
        chk("sp_rdata_hold", 64'(resp_rdata), 64'(32'hDEADBEEF));

        // Fairness: all ports valid, memory always ready and responding
        do_reset();
        req_valid = 4'b1111; mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h77;
        for (int k = 0; k < 8; k++) begin
            #1 chk("fair_grant", 64'(req_ready), 64'(1 << (k % 4)));
            @(negedge clk);
        end
        req_valid = '0; mem_resp_valid = 1'b0;
`ifdef TILE_MEM_ARB_PERF_EN
        #1;
        for (int p = 0; p < NP; p++) chk("perf_grant_cnt", 64'(grant_cnt[p*32 +: 32]), 64'(2));
        chk("perf_stall_cnt", 64'(stall_cnt), 64'(0));
`endif

        // Outstanding limit: no responses, exactly MO fires
        do_reset();
        req_valid = 4'b0001; mem_req_ready = 1'b1; fires = 0;
        for (int k = 0; k < 8; k++) begin
            #1 if (mem_req_valid && mem_req_ready) fires++;
            @(negedge clk);
        end
        chk("ol_fires", 64'(fires), 64'(MO));
        #1;
        chk("ol_full_valid", 64'(mem_req_valid), 64'(0));
        chk("ol_full_ready", 64'(req_ready), 64'(0));
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("ol_refire_valid", 64'(mem_req_valid), 64'(1));
        chk("ol_refire_ready", 64'(req_ready), 64'(4'b0001));
        @(negedge clk); #1;
        chk("ol_full_again", 64'(mem_req_valid), 64'(0));

        // Ordering: ports 3,1,0 back to back, responses A,B,C
        do_reset();
        mem_req_ready = 1'b1;
        ord_data[0] = 32'hA; ord_data[1] = 32'hB; ord_data[2] = 32'hC;
        ord_hot[0] = 4'b1000; ord_hot[1] = 4'b0010; ord_hot[2] = 4'b0001;
        for (int j = 0; j < 3; j++) begin
            req_valid = ord_hot[j];
            #1 chk("ord_grant", 64'(req_ready), 64'(ord_hot[j]));
            @(negedge clk);
        end
        req_valid = '0;
        for (int j = 0; j < 4; j++) begin
            mem_resp_valid = (j < 3);
            mem_resp_rdata = (j < 3) ? ord_data[j] : 32'h0;
            #1;
            if (j > 0) begin
                chk("ord_resp_valid", 64'(resp_valid), 64'(ord_hot[j-1]));
                chk("ord_resp_rdata", 64'(resp_rdata), 64'(ord_data[j-1]));
            end
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;

        // Stray response with empty FIFO, then backpressure
        do_reset();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5A5A;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1 chk("stray_resp_valid", 64'(resp_valid), 64'(0));
        set_port(1, 32'h2222, 32'h3333, M_XWR, MT_H);
        req_valid = 4'b0010; mem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_req_ready", 64'(req_ready), 64'(0));
            chk("bp_mem_req_valid", 64'(mem_req_valid), 64'(1));
            chk("bp_addr_stable", 64'(mem_req_addr), 64'(32'h2222));
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        #1 chk("bp_fire", 64'(req_ready), 64'(4'b0010));
        @(negedge clk);
        req_valid = '0;

        // Reset mid-flight with two outstanding
        do_reset();
        req_valid = 4'b0001; mem_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        req_valid = 4'b1111; mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55;
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("mf_resp_valid", 64'(resp_valid), 64'(4'b0001));
        chk("mf_rr_after3", 64'(req_ready), 64'(4'b0010));
        #1 rst = 1'b1;
        #1;
        chk("mf_async_req_ready", 64'(req_ready), 64'(0));
        chk("mf_async_mem_valid", 64'(mem_req_valid), 64'(0));
        chk("mf_async_resp_valid", 64'(resp_valid), 64'(0));
        chk("mf_async_resp_rdata", 64'(resp_rdata), 64'(0));
        @(negedge clk);
        rst = 1'b0; req_valid = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 1) mem_resp_valid = 1'b0;
            #1 chk("mf_drop_resp", 64'(resp_valid), 64'(0));
        end
        req_valid = 4'b1111; mem_req_ready = 1'b1;
        #1 chk("mf_rr_reset", 64'(req_ready), 64'(4'b0001));
        @(negedge clk);

        // Random traffic against a queue-based model
        do_reset();
        for (int p = 0; p < NP; p++) pend[p] = 1'b0;
        idq.delete(); memq.delete();
        rr_m = 0; exp_rv = '0; exp_rd = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && $urandom_range(2) == 0) begin
                    pend[p] = 1'b1;
                    p_addr[p] = $urandom; p_wdata[p] = $urandom;
                    p_fcn[p] = ($urandom_range(1) == 1); p_typ[p] = 3'($urandom_range(7));
                end
                req_valid[p] = pend[p];
                set_port(p, p_addr[p], p_wdata[p], p_fcn[p], p_typ[p]);
            end
            mem_req_ready = ($urandom_range(3) != 0);
            if (memq.size() > 0) begin
                mem_resp_valid = ($urandom_range(1) == 1);
                mem_resp_rdata = memq[0];
            end else begin
                mem_resp_valid = ($urandom_range(7) == 0);
                mem_resp_rdata = $urandom;
            end
            #1;
            w = -1;
            for (int i = 0; i < NP; i++)
                if (w < 0 && pend[(rr_m + i) % NP]) w = (rr_m + i) % NP;
            exp_mv = (w >= 0) && (idq.size() < MO);
            fire_m = exp_mv && mem_req_ready;
            chk("rnd_mem_req_valid", 64'(mem_req_valid), 64'(exp_mv));
            chk("rnd_req_ready", 64'(req_ready), fire_m ? 64'(1 << w) : 64'(0));
            if (exp_mv) begin
                chk("rnd_addr", 64'(mem_req_addr), 64'(p_addr[w]));
                chk("rnd_wdata", 64'(mem_req_wdata), 64'(p_wdata[w]));
                chk("rnd_fcn", 64'(mem_req_fcn), 64'(p_fcn[w]));
                chk("rnd_typ", 64'(mem_req_typ), 64'(p_typ[w]));
            end
            chk("rnd_resp_valid", 64'(resp_valid), 64'(exp_rv));
            chk("rnd_resp_rdata", 64'(resp_rdata), 64'(exp_rd));
            if (mem_resp_valid && idq.size() > 0) begin
                exp_rv = NP'(1 << idq.pop_front());
                exp_rd = mem_resp_rdata;
                void'(memq.pop_front());
            end else begin
                exp_rv = '0;
            end
            if (fire_m) begin
                idq.push_back(w);
                memq.push_back($urandom);
                pend[w] = 1'b0;
                rr_m = (w + 1) % NP;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
